// File: rtl/hex_scan_driver_pkg.sv
// Shared display definitions for the hex scan driver.
//   NUM_DIGITS  : number of multiplexed digits
//   DIGIT_W     : width of the digit index
//   AN_OFF      : anode pattern with every digit dark (anodes are active-low)
//   disp_set_t  : one full display image (hex codes, points, blanks)
package hex_scan_driver_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam int         DIGIT_W    = 2;
  localparam logic [3:0] AN_OFF     = 4'b1111;

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] hex;
    logic [NUM_DIGITS-1:0]   point;
    logic [NUM_DIGITS-1:0]   blank;
  } disp_set_t;

  // Reset image: zero codes, no points, every digit blanked.
  localparam disp_set_t DISP_RESET = '{hex: '0, point: '0, blank: '1};

  function automatic logic [3:0] hex_digit(input logic [4*NUM_DIGITS-1:0] h,
                                           input logic [DIGIT_W-1:0]      s);
    return h[{s, 2'b00} +: 4];
  endfunction

  function automatic logic [NUM_DIGITS-1:0] an_for(input logic [DIGIT_W-1:0] s);
    logic [NUM_DIGITS-1:0] an;
    an    = AN_OFF;
    an[s] = 1'b0;
    return an;
  endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running dwell prescaler for the digit scan.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   tick  : high during the cycle the count equals SCAN_PERIOD-1
module scan_prescaler #(
  parameter int SCAN_PERIOD = 100000
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int             CW   = $clog2(SCAN_PERIOD);
  localparam logic [CW-1:0]  LAST = CW'(SCAN_PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (tick) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/hex_scan_driver.sv
// Four-digit multiplexed hex display driver.
//   clk, rst_n          : system clock, asynchronous active-low reset
//   load                : capture strobe for hex_in / point_in / blank_in
//   hex_in              : four hex digits, digit k in hex_in[4k+3:4k]
//   point_in, blank_in  : per-digit decimal point / blank requests
//   D, point, LE        : registered code, point and blank for the downstream decoder
//   AN                  : active-low digit anodes, one low while scanning
//   digit_sel           : index of the digit currently driven
//   frame               : one-cycle pulse after the digit 3 -> 0 wrap
// New values land in a staging set and are copied to the displayed set only
// at the end of a frame, so a frame never mixes old and new digits.
module hex_scan_driver
  import hex_scan_driver_pkg::*;
#(
  parameter int SCAN_PERIOD = 100000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] hex_in,
  input  logic [NUM_DIGITS-1:0]   point_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  output logic [3:0]              D,
  output logic                    point,
  output logic                    LE,
  output logic [NUM_DIGITS-1:0]   AN,
  output logic [DIGIT_W-1:0]      digit_sel,
  output logic                    frame
);

  logic tick;

  scan_prescaler #(
    .SCAN_PERIOD (SCAN_PERIOD)
  ) u_prescaler (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  logic [DIGIT_W-1:0]    sel_q, sel_d;
  logic                  pend_q, pend_d;
  logic                  frame_q, frame_d;
  disp_set_t             stg_q, stg_d;
  disp_set_t             act_q, act_d;
  disp_set_t             in_set;
  logic                  commit;
  logic [3:0]            d_q, d_d;
  logic                  pt_q, pt_d;
  logic                  le_q, le_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  always_comb begin
    in_set = '{hex: hex_in, point: point_in, blank: blank_in};
    commit = tick && (sel_q == DIGIT_W'(NUM_DIGITS - 1));

    sel_d = sel_q;
    if (tick) sel_d = sel_q + DIGIT_W'(1);

    stg_d = stg_q;
    if (load) stg_d = in_set;

    // A load on the commit edge bypasses staging so the newest value wins.
    act_d  = act_q;
    pend_d = pend_q;
    if (commit) begin
      if (load)        act_d = in_set;
      else if (pend_q) act_d = stg_q;
      pend_d = 1'b0;
    end else if (load) begin
      pend_d = 1'b1;
    end

    frame_d = commit;

    // Outputs track the post-edge digit and image so they move with digit_sel.
    d_d  = hex_digit(act_d.hex, sel_d);
    pt_d = act_d.point[sel_d];
    le_d = act_d.blank[sel_d];
    an_d = an_for(sel_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_q   <= '0;
      pend_q  <= 1'b0;
      frame_q <= 1'b0;
      stg_q   <= DISP_RESET;
      act_q   <= DISP_RESET;
      d_q     <= '0;
      pt_q    <= 1'b0;
      le_q    <= 1'b1;
      an_q    <= AN_OFF;
    end else begin
      sel_q   <= sel_d;
      pend_q  <= pend_d;
      frame_q <= frame_d;
      stg_q   <= stg_d;
      act_q   <= act_d;
      d_q     <= d_d;
      pt_q    <= pt_d;
      le_q    <= le_d;
      an_q    <= an_d;
    end
  end

  assign D         = d_q;
  assign point     = pt_q;
  assign LE        = le_q;
  assign AN        = an_q;
  assign digit_sel = sel_q;
  assign frame     = frame_q;

endmodule

// File: tb/tb_hex_scan_driver.sv
module tb_hex_scan_driver;

  localparam int P = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        load = 1'b0;
  logic [15:0] hex_in = '0;
  logic [3:0]  point_in = '0;
  logic [3:0]  blank_in = '0;
  logic [3:0]  D;
  logic        point;
  logic        LE;
  logic [3:0]  AN;
  logic [1:0]  digit_sel;
  logic        frame;

  int checks = 0;
  int fails  = 0;

  // Reference model: edges since reset plus staging/active images.
  int          n;
  logic [15:0] s_hex, a_hex;
  logic [3:0]  s_pt, s_bl, a_pt, a_bl;
  bit          pend, m_frame;

  hex_scan_driver #(.SCAN_PERIOD(P)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .hex_in    (hex_in),
    .point_in  (point_in),
    .blank_in  (blank_in),
    .D         (D),
    .point     (point),
    .LE        (LE),
    .AN        (AN),
    .digit_sel (digit_sel),
    .frame     (frame)
  );

  always #5 clk = ~clk;

  function automatic int e_sel();
    return (n / P) % 4;
  endfunction

  function automatic logic [3:0] e_an();
    logic [3:0] v;
    v = 4'b1111;
    v[e_sel()] = 1'b0;
    return v;
  endfunction

  function automatic logic [3:0] e_d();
    return 4'(a_hex >> (4 * e_sel()));
  endfunction

  function automatic logic [12:0] e_all();
    return {e_d(), a_pt[e_sel()], a_bl[e_sel()], e_an(), 2'(e_sel()), m_frame};
  endfunction

  task automatic model_reset();
    n = 0; pend = 0; m_frame = 0;
    s_hex = '0; a_hex = '0; s_pt = '0; a_pt = '0; s_bl = 4'hF; a_bl = 4'hF;
  endtask

  task automatic step(input logic ld, input logic [15:0] h, input logic [3:0] p, input logic [3:0] b);
    bit commit;
    load = ld; hex_in = h; point_in = p; blank_in = b;
    @(posedge clk);
    commit = ((n % P) == P - 1) && (e_sel() == 3);
    if (commit) begin
      if (ld) begin a_hex = h; a_pt = p; a_bl = b; end
      else if (pend) begin a_hex = s_hex; a_pt = s_pt; a_bl = s_bl; end
      pend = 0;
    end else if (ld) pend = 1;
    if (ld) begin s_hex = h; s_pt = p; s_bl = b; end
    m_frame = commit;
    n++;
    #1;
  endtask

  task automatic idle();
    step(1'b0, 16'($urandom), 4'($urandom), 4'($urandom));
  endtask

  task automatic idle_until_sel(input int s);
    for (int i = 0; i < 64 && e_sel() != s; i++) idle();
    checks++;
    if (e_sel() != s) begin fails++; $display("FAIL seek_digit got %0d want %0d", e_sel(), s); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks += 6;
    if (D !== 4'h0)         begin fails++; $display("FAIL reset_D got %h want 0", D); end
    if (point !== 1'b0)     begin fails++; $display("FAIL reset_point got %b want 0", point); end
    if (LE !== 1'b1)        begin fails++; $display("FAIL reset_LE got %b want 1", LE); end
    if (AN !== 4'b1111)     begin fails++; $display("FAIL reset_AN got %b want 1111", AN); end
    if (digit_sel !== 2'd0) begin fails++; $display("FAIL reset_sel got %0d want 0", digit_sel); end
    if (frame !== 1'b0)     begin fails++; $display("FAIL reset_frame got %b want 0", frame); end
    #2 rst_n = 1'b1;
    model_reset();
    idle();
    checks++;
    if (AN !== 4'b1110 || LE !== 1'b1) begin
      fails++; $display("FAIL first_edge AN=%b LE=%b want 1110/1", AN, LE);
    end
  endtask

  task automatic test_idle_scan();
    int frames = 0, m_frames = 0;
    for (int i = 0; i < 40; i++) begin
      idle();
      if (frame) frames++;
      if (m_frame) m_frames++;
      checks++;
      if ({D, point, LE, AN, digit_sel, frame} !== e_all()) begin
        fails++; $display("FAIL idle_scan n=%0d got %h want %h", n, {D, point, LE, AN, digit_sel, frame}, e_all());
      end
    end
    checks++;
    if (frames != m_frames || frames != 2) begin
      fails++; $display("FAIL frame_count got %0d want %0d", frames, m_frames);
    end
  endtask

  task automatic test_load_commit();
    bit seen = 0;
    idle_until_sel(1);
    step(1'b1, 16'h1234, 4'b0101, 4'b0000);
    for (int i = 0; i < 32; i++) begin
      idle();
      checks++;
      if ({D, point, LE, AN, digit_sel, frame} !== e_all()) begin
        fails++; $display("FAIL load_commit n=%0d got %h want %h", n, {D, point, LE, AN, digit_sel, frame}, e_all());
      end
      if (m_frame && !seen) begin
        seen = 1;
        checks++;
        if (D !== 4'h4 || point !== 1'b1 || LE !== 1'b0 || AN !== 4'b1110) begin
          fails++; $display("FAIL commit_digit0 D=%h point=%b LE=%b AN=%b want 4/1/0/1110", D, point, LE, AN);
        end
      end
    end
  endtask

  task automatic test_overwrite();
    int seen_a = 0;
    idle_until_sel(1);
    step(1'b1, 16'hAAAA, 4'h0, 4'h0);
    idle(); idle();
    step(1'b1, 16'h5555, 4'h0, 4'h0);
    for (int i = 0; i < 32; i++) begin
      idle();
      if (D === 4'hA && LE === 1'b0) seen_a++;
      checks++;
      if ({D, point, LE, AN, digit_sel, frame} !== e_all()) begin
        fails++; $display("FAIL overwrite n=%0d got %h want %h", n, {D, point, LE, AN, digit_sel, frame}, e_all());
      end
    end
    checks++;
    if (seen_a != 0) begin fails++; $display("FAIL overwrite_stale got %0d A cycles want 0", seen_a); end
  endtask

  task automatic test_commit_edge_load();
    for (int i = 0; i < 64 && !((n % P) == P - 1 && e_sel() == 3); i++) idle();
    step(1'b1, 16'hBEEF, 4'h0, 4'h0);
    checks++;
    if (D !== 4'hF || digit_sel !== 2'd0 || AN !== 4'b1110 || LE !== 1'b0) begin
      fails++; $display("FAIL commit_edge_load D=%h sel=%0d AN=%b LE=%b want F/0/1110/0", D, digit_sel, AN, LE);
    end
    for (int i = 0; i < 16; i++) begin
      idle();
      checks++;
      if ({D, point, LE, AN, digit_sel, frame} !== e_all()) begin
        fails++; $display("FAIL commit_edge_run n=%0d got %h want %h", n, {D, point, LE, AN, digit_sel, frame}, e_all());
      end
    end
  endtask

  task automatic test_blank();
    bit committed = 0;
    idle_until_sel(0);
    step(1'b1, 16'h8421, 4'h0, 4'b1000);
    for (int i = 0; i < 40; i++) begin
      idle();
      if (m_frame) committed = 1;
      checks++;
      if ({D, point, LE, AN, digit_sel, frame} !== e_all()) begin
        fails++; $display("FAIL blank n=%0d got %h want %h", n, {D, point, LE, AN, digit_sel, frame}, e_all());
      end
      if (committed) begin
        checks++;
        if (LE !== (AN == 4'b0111)) begin
          fails++; $display("FAIL blank_digit3 LE=%b AN=%b want LE high only at 0111", LE, AN);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    int le_low = 0;
    idle_until_sel(2);
    step(1'b1, 16'h9999, 4'hF, 4'h0);
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (AN !== 4'b1111 || LE !== 1'b1 || digit_sel !== 2'd0) begin
      fails++; $display("FAIL async_reset AN=%b LE=%b sel=%0d want 1111/1/0", AN, LE, digit_sel);
    end
    #2 rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < 40; i++) begin
      idle();
      if (LE !== 1'b1) le_low++;
      checks++;
      if ({D, point, LE, AN, digit_sel, frame} !== e_all()) begin
        fails++; $display("FAIL reset_mid n=%0d got %h want %h", n, {D, point, LE, AN, digit_sel, frame}, e_all());
      end
    end
    checks++;
    if (le_low != 0) begin fails++; $display("FAIL pending_discard got %0d unblanked cycles want 0", le_low); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 5) == 0, 16'($urandom), 4'($urandom), 4'($urandom));
      checks++;
      if ({D, point, LE, AN, digit_sel, frame} !== e_all()) begin
        fails++; $display("FAIL random n=%0d got %h want %h", n, {D, point, LE, AN, digit_sel, frame}, e_all());
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_idle_scan();
    test_load_commit();
    test_overwrite();
    test_commit_edge_load();
    test_blank();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/hex_scan_driver.md
HEX_SCAN_DRIVER -- requirements
Module: hex_scan_driver

Interface
REQ-001 Parameter SCAN_PERIOD, default 100000, meaning clk cycles each digit is displayed; legal range >= 2.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 load  input  1  capture strobe for hex_in/point_in/blank_in, sampled on a rising clk edge.
REQ-005 hex_in  input  16  four hex digits; digit k = hex_in[4k+3:4k].
REQ-006 point_in  input  4  per-digit decimal point request; bit k belongs to digit k.
REQ-007 blank_in  input  4  per-digit blank request; bit k = 1 blanks digit k.
REQ-008 D  output  4  hex code of the current digit, feeding the downstream decoder D3..D0.
REQ-009 point  output  1  decimal point of the current digit, feeding the downstream decoder point input.
REQ-010 LE  output  1  blank control for the downstream decoder; 1 = blanked.
REQ-011 AN  output  4  digit anodes, active-low, one-hot-low while scanning.
REQ-012 digit_sel  output  2  index of the digit currently driven.
REQ-013 frame  output  1  one-cycle pulse marking the digit 3 -> 0 wrap.

Function
REQ-014 Prescaler counts 0..SCAN_PERIOD-1 and wraps; tick is asserted in the cycle the count equals SCAN_PERIOD-1.
REQ-015 digit_sel increments modulo 4 on each tick (3 wraps to 0).
REQ-016 frame is asserted for exactly the one cycle after the edge on which digit_sel wraps 3 -> 0.
REQ-017 Inputs go to a staging register set, and display uses a separate active register set, so a new value is never shown part-way through a frame.
REQ-018 load = 1 on an edge writes hex_in, point_in and blank_in into staging and sets pending; a later load before commit overwrites staging (last write wins).
REQ-019 On the edge where tick = 1 and digit_sel = 3 (commit edge):
- active <= staging if pending = 1;
- pending is cleared.
REQ-020 If load = 1 on a commit edge, active takes hex_in/point_in/blank_in directly (newest wins), and pending ends cleared.
REQ-021 D, point, LE and AN are registered outputs. On every edge they load, for index s = the digit_sel value after that edge:
- D <= active hex digit s
- point <= active point bit s
- LE <= active blank bit s
- AN <= 4'b1111 with bit s cleared
REQ-022 Latency: D/point/LE/AN change on the same edge as digit_sel; a committed value appears on digit 0 in the cycle after the commit edge.
REQ-023 Exactly one AN bit is low in every cycle after the first clock following reset release.
REQ-024 Blanking applies through LE only; AN still scans a blanked digit.

Reset
REQ-025 While rst_n = 0:
- prescaler = 0, digit_sel = 0, pending = 0, frame = 0;
- staging and active hex = 0, point = 0, blank = 4'b1111;
- D = 0, point = 0, LE = 1, AN = 4'b1111.
REQ-026 Assertion of rst_n mid-frame takes effect immediately without a clock and discards any pending load.
REQ-027 After reset release, scanning restarts at digit 0 with a full SCAN_PERIOD dwell, and the display stays blank until the first commit.

Structure
REQ-028 A shared header, disp_defs.vh, defines NUM_DIGITS = 4, AN_OFF = 4'b1111 and the digit index width 2.
REQ-029 The prescaler is a separate sub-module, scan_prescaler, with parameter SCAN_PERIOD and output tick.
REQ-030 The block instantiates no decoder; its D/point/LE outputs connect port-for-port to the downstream 7-segment decoder.

Verification (SCAN_PERIOD = 4)
REQ-031 Reset release with no load -> AN cycles 1110, 1101, 1011, 0111 every 4 clks, LE = 1 throughout, frame pulses every 16 clks.
REQ-032 load with hex_in = 16'h1234, point_in = 4'b0101, blank_in = 0 at mid-frame -> no output change until the commit edge, then digit 0 shows D = 4, point = 1; digit 1 shows D = 3, point = 0; digit 2 shows D = 2; digit 3 shows D = 1; LE = 0.
REQ-033 load 16'hAAAA, then load 16'h5555 before commit -> only 5 is ever displayed.
REQ-034 load 16'hBEEF asserted exactly on a commit edge -> digit 0 shows D = F in the following cycle.
REQ-035 blank_in = 4'b1000 committed -> LE = 1 only while AN = 0111.
REQ-036 rst_n pulsed low for 3 ns with pending = 1 at digit 2 -> AN = 1111 and LE = 1 immediately, and the pending value is never displayed.
